// File: rtl/parity_tx_pkg.sv
// Shared types and default parameters for the parity frame serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: tx_state_t FSM encoding, default frame width and bit period.
package parity_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int FRAME_W_DEF      = 5;
   localparam int CLKS_PER_BIT_DEF = 4;

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// Latency: tick is combinational from the registered count.
// Backpressure: none; free-running except when cleared.
// Ports: clk, rst (sync, active-high), clear (restart period at 0), tick (last cycle of period).
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      // Explicit wrap so non-power-of-two periods work.
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial transmitter for {parity, data} frames: start bit, frame LSB first, stop bit.
// Latency: start bit on tx the cycle after accept; done pulses (FRAME_W+2)*CLKS_PER_BIT+1 cycles after accept.
// Backpressure: in_ready only in IDLE (and not in reset); inputs are ignored while a frame is in flight.
// Ports: clk, rst (sync, active-high), in_valid/in_frame/in_ready handshake, tx line, busy, done pulse.
module parity_frame_tx
   import parity_tx_pkg::*;
#(
   parameter int FRAME_W      = FRAME_W_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [FRAME_W-1:0] in_frame,
   output logic               in_ready,
   output logic               tx,
   output logic               busy,
   output logic               done
);

   localparam int IW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_W - 1);

   tx_state_t          state_q, state_d;
   logic [FRAME_W-1:0] shift_q, shift_d;
   logic [FRAME_W-1:0] shift_nxt;
   logic [IW-1:0]      idx_q, idx_d;
   logic               tx_q, tx_d;
   logic               done_q, done_d;
   logic               timer_clr;
   logic               tick;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(timer_clr),
      .tick (tick)
   );

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign busy      = (state_q != IDLE);
   assign tx        = tx_q;
   assign done      = done_q;
   assign shift_nxt = shift_q >> 1;

   // tx_d is the line level for the state being entered, so tx stays a flop
   // and changes on the same edge as the state.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      timer_clr = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (in_valid) begin
               shift_d   = in_frame;
               idx_d     = '0;
               timer_clr = 1'b1;
               tx_d      = 1'b0;
               state_d   = START;
            end
         end
         START: begin
            if (tick) begin
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d = shift_nxt;
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shift_nxt[0];
               end
            end
         end
         STOP: begin
            if (tick) begin
               tx_d    = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: one instance at CLKS_PER_BIT=4, one at CLKS_PER_BIT=1.
// Expected line levels come from the frame timing rules (bit slot = (cycle-1)/CLKS_PER_BIT).
module tb_parity_frame_tx;

   localparam int FW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          v_a, v_b;
   logic [FW-1:0] f_a, f_b;
   logic          rdy_a, rdy_b;
   logic          tx_a, tx_b;
   logic          busy_a, busy_b;
   logic          done_a, done_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   parity_frame_tx #(.FRAME_W(FW), .CLKS_PER_BIT(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(v_a), .in_frame(f_a), .in_ready(rdy_a),
      .tx(tx_a), .busy(busy_a), .done(done_a)
   );

   parity_frame_tx #(.FRAME_W(FW), .CLKS_PER_BIT(1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(v_b), .in_frame(f_b), .in_ready(rdy_b),
      .tx(tx_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: cycle n after accept falls in bit slot (n-1)/c.
   // Slot 0 is the start bit, slots 1..FW carry frame bits, then stop/idle high.
   function automatic logic exp_tx(input logic [FW-1:0] f, input int n, input int c);
      int slot;
      slot = (n - 1) / c;
      if (slot == 0) return 1'b0;
      if (slot <= FW) return f[slot-1];
      return 1'b1;
   endfunction

   function automatic logic s_tx(input bit sel);   return sel ? tx_b   : tx_a;   endfunction
   function automatic logic s_rdy(input bit sel);  return sel ? rdy_b  : rdy_a;  endfunction
   function automatic logic s_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
   function automatic logic s_done(input bit sel); return sel ? done_b : done_a; endfunction

   function automatic logic [FW-1:0] rnd_frame();
      return FW'($urandom);
   endfunction

   // Entered #1 after an edge with the DUT idle; returns #1 after the edge that
   // starts the done cycle. hold keeps in_valid high into the done cycle.
   task automatic send(input bit sel, input logic [FW-1:0] f, input bit hold, input bit toggle);
      int c;
      int len;
      c   = sel ? 1 : 4;
      len = (FW + 2) * c;
      if (sel) begin v_b = 1'b1; f_b = f; end
      else     begin v_a = 1'b1; f_a = f; end
      chk("accept_ready", s_rdy(sel), 1);
      @(posedge clk); #1;
      for (int n = 1; n <= len; n++) begin
         if (toggle) begin
            if (sel) f_b = rnd_frame(); else f_a = rnd_frame();
         end else if (!hold) begin
            if (sel) v_b = 1'b0; else v_a = 1'b0;
         end
         chk($sformatf("tx_c%0d", n), s_tx(sel), exp_tx(f, n, c));
         chk("busy_inflight", s_busy(sel), 1);
         chk("ready_inflight", s_rdy(sel), 0);
         chk("done_early", s_done(sel), 0);
         @(posedge clk); #1;
      end
      chk("done_pulse", s_done(sel), 1);
      chk("ready_after", s_rdy(sel), 1);
      chk("busy_after", s_busy(sel), 0);
      chk("tx_gap_high", s_tx(sel), 1);
      if (!hold) begin
         if (sel) v_b = 1'b0; else v_a = 1'b0;
      end
   endtask

   initial begin
      logic [FW-1:0] f;
      rst = 1'b1;
      v_a = 1'b0; v_b = 1'b0;
      f_a = '0;   f_b = '0;

      // Reset and idle
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_tx", tx_a, 1);
         chk("rst_busy", busy_a, 0);
         chk("rst_done", done_a, 0);
         chk("rst_ready", rdy_a, 0);
         chk("rst_ready_b", rdy_b, 0);
      end
      rst = 1'b0;
      #1;
      chk("idle_ready", rdy_a, 1);
      chk("idle_ready_b", rdy_b, 1);
      @(posedge clk); #1;
      chk("idle_tx", tx_a, 1);
      chk("idle_done", done_a, 0);

      // Single frame
      send(1'b0, 5'b1_0110, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("done_one_cycle", done_a, 0);

      // Back-to-back with in_valid held high
      send(1'b0, 5'b0_1111, 1'b1, 1'b0);
      send(1'b0, 5'b1_0000, 1'b0, 1'b0);

      // Input toggling while busy
      send(1'b0, rnd_frame(), 1'b0, 1'b1);

      // Random frames, including a back-to-back pair
      for (int i = 0; i < 4; i++) send(1'b0, rnd_frame(), 1'b0, 1'b0);
      send(1'b0, rnd_frame(), 1'b1, 1'b0);
      send(1'b0, rnd_frame(), 1'b0, 1'b0);

      // Reset during data bit 2 (cycles 13..16)
      f   = rnd_frame();
      v_a = 1'b1; f_a = f;
      @(posedge clk); #1;
      v_a = 1'b0;
      for (int n = 1; n < 14; n++) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_bit2", tx_a, exp_tx(f, 14, 4));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_tx", tx_a, 1);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_done", done_a, 0);
      chk("midrst_ready", rdy_a, 0);
      rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         chk("postrst_done", done_a, 0);
         chk("postrst_tx", tx_a, 1);
      end
      send(1'b0, rnd_frame(), 1'b0, 1'b0);

      // CLKS_PER_BIT = 1
      send(1'b1, 5'b1_1010, 1'b0, 1'b0);
      send(1'b1, rnd_frame(), 1'b1, 1'b0);
      send(1'b1, rnd_frame(), 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("b_done_one_cycle", done_b, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
